seq_multdiv: RTL and testbench

- Iterative signed 32-bit multiply/divide unit in the execute stage, alongside the ALU and barrel shifters.
- Consumes mul/div requests decoded from the instruction and returns a 32-bit result with an exception flag.
- Multiply is radix-2 shift-add; divide is restoring shift-subtract. One iteration per clock.
- The pipeline stalls while a request is in progress and resumes on `data_resultRDY`.

---
 rtl/seq_multdiv_pkg.sv | 15 +
 rtl/seq_multdiv_iter_counter.sv | 40 ++++
 rtl/seq_multdiv.sv | 142 ++++++++++++++
 tb/tb_seq_multdiv.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seq_multdiv_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide unit.
package seq_multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/seq_multdiv_iter_counter.sv
// Iteration counter: synchronous clear on start, increment per iteration,
// terminal flag on the last iteration (count == ITER-1).
module iter_counter
    import seq_multdiv_pkg::*;
#(
    parameter int CNT_W = MD_CNT_W,
    parameter int ITER  = MD_ITER
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminal = (cnt_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/seq_multdiv.sv
// Iterative signed multiply (radix-2 shift-add) / divide (restoring) unit,
// one iteration per clock, result registered on entry to DONE.
module seq_multdiv
    import seq_multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITER  = MD_ITER,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    state_e             state_q, state_d;
    // Multiply: {product_hi, multiplier}. Divide: {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;

    logic               start;
    logic               busy;
    logic               last_iter;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] mul_signed;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   div_signed;

    assign start = ctrl_MULT | ctrl_DIV;
    assign busy  = (state_q == ST_MUL) || (state_q == ST_DIV);

    iter_counter #(
        .CNT_W (CNT_W),
        .ITER  (ITER)
    ) u_iter_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (start),
        .inc      (busy && !start),
        .terminal (last_iter)
    );

    always_comb begin
        a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
        mul_signed = neg_q ? -mul_next : mul_next;

        // Carry-out of the trial subtraction means the remainder went negative: restore.
        rem_sh   = acc_q[2*WIDTH-2:WIDTH-1];
        trial    = rem_sh - {1'b0, mag_q};
        div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
        div_signed = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mag_d    = mag_q;
        neg_d    = neg_q;
        result_d = result_q;
        exc_d    = exc_q;

        unique case (state_q)
            ST_MUL: begin
                acc_d = mul_next;
                if (last_iter) begin
                    state_d  = ST_DONE;
                    result_d = mul_signed[WIDTH-1:0];
                    exc_d    = (mul_signed[2*WIDTH-1:WIDTH] != {WIDTH{mul_signed[WIDTH-1]}});
                end
            end
            ST_DIV: begin
                acc_d = div_next;
                if (last_iter) begin
                    state_d = ST_DONE;
                    if (mag_q == '0) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        // A non-negated quotient magnitude of 2^(WIDTH-1) only arises from MIN / -1.
                        result_d = div_signed;
                        exc_d    = div_next[WIDTH-1] & ~neg_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new request always wins, aborting whatever is in flight.
        if (start) begin
            neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            if (ctrl_MULT) begin
                state_d = ST_MUL;
                acc_d   = {{WIDTH{1'b0}}, b_mag};
                mag_d   = a_mag;
            end else begin
                state_d = ST_DIV;
                acc_d   = {{WIDTH{1'b0}}, a_mag};
                mag_d   = b_mag;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mag_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mag_q    <= mag_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_multdiv.sv
// Self-checking bench for seq_multdiv: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_seq_multdiv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    seq_multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Signed arithmetic reference: 64-bit product, truncating quotient.
    function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint sa, sb, p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (is_mul) begin
            p = sa * sb;
            r = p[31:0];
            e = (p != longint'(signed'(p[31:0])));
        end else if (b == 32'h0) begin
            r = 32'h0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
            e = 1'b0;
        end
    endfunction

    // Launch one request, scramble operands after E0, then watch 36 edges for the ready pulse.
    task automatic do_op(input string tag, input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_r;
        logic        exp_e;
        int          pulses;
        int          at;
        model(is_mul, a, b, exp_r, exp_e);
        @(negedge clock);
        ctrl_MULT     = is_mul;
        ctrl_DIV      = !is_mul;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        pulses = 0;
        at     = 0;
        for (int i = 1; i <= 36; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                pulses++;
                at = i;
            end
        end
        check({tag, "_rdy_cycle"}, 32'(at), 32'd32);
        check({tag, "_rdy_count"}, 32'(pulses), 32'd1);
        check({tag, "_result"}, data_result, exp_r);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_e});
    endtask

    initial begin
        int          pulses;
        int          at;
        bit          is_mul;
        logic [31:0] a, b;

        repeat (3) @(posedge clock);
        #1;
        check("reset_result", data_result, 32'h0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        do_op("mul_7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD);
        check("mul_7x-3_value", data_result, 32'hFFFF_FFEB);
        do_op("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000);
        do_op("mul_min_x1", 1'b1, 32'h8000_0000, 32'd1);
        do_op("div_-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        check("div_-7/2_value", data_result, 32'hFFFF_FFFD);
        do_op("div_100/7", 1'b0, 32'd100, 32'd7);
        do_op("div_by_zero", 1'b0, 32'd5, 32'd0);
        do_op("div_min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

        // Abort: a divide pulsed 10 cycles into a multiply replaces it.
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        pulses = 0;
        at     = 0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) pulses++;
        end
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd20;
        data_operandB = 32'd5;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                pulses++;
                at = i;
            end
        end
        check("abort_rdy_count", 32'(pulses), 32'd1);
        check("abort_rdy_cycle", 32'(at), 32'd32);
        check("abort_result", data_result, 32'd4);

        // Reset during iteration 15 of a multiply.
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd6;
        data_operandB = 32'd7;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset_result", data_result, 32'h0);
        check("midreset_exc", {31'd0, data_exception}, 32'd0);
        check("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
        pulses = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) pulses++;
        end
        check("midreset_no_rdy", 32'(pulses), 32'd0);
        do_op("mul_6x7", 1'b1, 32'd6, 32'd7);
        check("mul_6x7_value", data_result, 32'd42);

        for (int k = 0; k < 24; k++) begin
            is_mul = k[0];
            a = $urandom;
            b = $urandom;
            if (k % 3 == 1) begin
                a = $urandom_range(0, 65535) - 32'd32768;
                b = $urandom_range(0, 65535) - 32'd32768;
            end else if (k % 3 == 2 && !is_mul) begin
                b = $urandom_range(1, 300);
                if (k % 4 == 2) b = -b;
            end
            do_op($sformatf("rand%0d", k), is_mul, a, b);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
